// File: rtl/sd_sector_sequencer.sv
// Reads a run of consecutive SD blocks through sd_card into a 512-byte sram buffer,
// then streams each buffered sector to a downstream scanner over valid/ready.
module sd_sector_sequencer #(
    parameter logic [31:0] START_BLK = 32'h2000,
    parameter int unsigned MAX_BLKS  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] cur_blk,
    input  logic        sd_init_finished,
    output logic        sd_rd_req,
    output logic [31:0] sd_blk_addr,
    input  logic [7:0]  sd_dout,
    input  logic        sd_valid,
    output logic        sram_we,
    output logic [8:0]  sram_addr,
    output logic [7:0]  sram_din,
    input  logic [7:0]  sram_dout,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_last,
    input  logic        byte_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [9:0]  fill_cnt;
    logic [8:0]  rd_ptr;
    logic        fetched;
    logic        stop_pend;
    logic [31:0] blk_cnt;

    logic fill_full;
    logic handshake;
    logic last_blk;

    assign fill_full   = fill_cnt[9];
    assign handshake   = byte_valid & byte_ready;
    assign last_blk    = (blk_cnt + 32'd1) == MAX_BLKS;
    assign sd_blk_addr = cur_blk;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        sd_rd_req  = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_din   = sd_dout;
        unique case (state)
            S_IDLE: begin
                if (start && sd_init_finished) state_next = S_REQ;
            end
            S_REQ: begin
                sd_rd_req  = 1'b1;
                state_next = S_FILL;
            end
            S_FILL: begin
                sram_addr = fill_cnt[8:0];
                sram_we   = sd_valid & ~fill_full;
                // sd_card cannot abort a block, so a stop only takes effect once the fill is complete
                if (fill_full) state_next = (stop_pend || stop) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                sram_addr = rd_ptr;
                if (stop)                         state_next = S_DONE;
                else if (handshake && byte_last) state_next = S_NEXT;
            end
            S_NEXT: begin
                state_next = last_blk ? S_DONE : S_REQ;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_blk    <= START_BLK;
            err        <= 1'b0;
            blk_cnt    <= '0;
            fill_cnt   <= '0;
            rd_ptr     <= '0;
            fetched    <= 1'b0;
            stop_pend  <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && sd_init_finished) begin
                        cur_blk   <= START_BLK;
                        blk_cnt   <= '0;
                        err       <= 1'b0;
                        stop_pend <= 1'b0;
                    end
                end
                S_REQ: begin
                    fill_cnt <= '0;
                    rd_ptr   <= '0;
                    fetched  <= 1'b0;
                    if (stop) stop_pend <= 1'b1;
                end
                S_FILL: begin
                    if (sram_we) fill_cnt <= fill_cnt + 10'd1;
                    if (stop)    stop_pend <= 1'b1;
                end
                S_DRAIN: begin
                    // rd_ptr already addresses the following byte while the current one waits,
                    // so sram_dout is ready the cycle after a handshake
                    fetched <= 1'b1;
                    if (handshake || stop) begin
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
                    end else if (!byte_valid && fetched) begin
                        byte_valid <= 1'b1;
                        byte_data  <= sram_dout;
                        byte_last  <= (rd_ptr == 9'd511);
                        rd_ptr     <= rd_ptr + 9'd1;
                        fetched    <= 1'b0;
                    end
                end
                S_NEXT: begin
                    blk_cnt <= blk_cnt + 32'd1;
                    if (last_blk) err <= 1'b1;
                    else          cur_blk <= cur_blk + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_sequencer.sv
// Self-checking bench: sd_card, sram and scanner models around the sequencer, with a
// table of run scenarios plus hand-written start/reset sequences.
module tb_sd_sector_sequencer;

    localparam logic [31:0] START_BLK = 32'h2000;
    localparam int          MAX_BLKS  = 3;
    localparam int M_NONE = 0, M_FILL = 1, M_DRAIN = 2, M_LAST = 3;

    logic        clk, reset, start, stop, busy, done, err;
    logic [31:0] cur_blk, sd_blk_addr;
    logic        sd_init_finished, sd_rd_req, sd_valid;
    logic [7:0]  sd_dout, sram_din, sram_dout, byte_data;
    logic        sram_we, byte_valid, byte_last, byte_ready;
    logic [8:0]  sram_addr;

    sd_sector_sequencer #(.START_BLK(START_BLK), .MAX_BLKS(MAX_BLKS)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .busy(busy), .done(done), .err(err), .cur_blk(cur_blk),
        .sd_init_finished(sd_init_finished), .sd_rd_req(sd_rd_req), .sd_blk_addr(sd_blk_addr),
        .sd_dout(sd_dout), .sd_valid(sd_valid),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          mode;
        int          stop_blk;
        int          ready_pct;
        int          exp_blocks;
        logic        exp_err;
        logic [31:0] exp_cur_blk;
    } run_t;

    run_t tbl [7];

    int n_checks, n_pass, cyc;

    // sram model
    logic [7:0] mem [512];
    logic       cap_we;
    logic [8:0] cap_addr;
    logic [7:0] cap_din;

    // sd_card model
    bit          sd_pend, sd_act;
    int          sd_idx;
    logic [31:0] sd_addr;

    // run-level reference model
    bit          exp_busy, exp_err, draining, prev_hs, prev_stall;
    bit          stop_sent, fill_stop_pend;
    int          req_due, done_due, err_due, first_valid_due, hs_cyc, hs_idx;
    int          blk_no, req_cnt, done_cnt, mode, stop_blk, ready_pct;
    logic [31:0] exp_addr, exp_drain_blk;
    logic [7:0]  prev_data;
    logic        prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // Content the sd_card model returns for byte i of block a; block START_BLK gives i%256.
    function automatic logic [7:0] blk_byte(input logic [31:0] a, input int i);
        logic [31:0] v;
        v = 32'(i) + (a - START_BLK) * 32'd3;
        return v[7:0];
    endfunction

    function automatic int mem_mismatches(input logic [31:0] a);
        int n;
        n = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== blk_byte(a, i)) n++;
        return n;
    endfunction

    task automatic clear_model();
        exp_busy = 0; exp_err = 0; draining = 0; prev_hs = 0; prev_stall = 0;
        sd_pend = 0; sd_act = 0; sd_idx = 0;
        req_due = -1; done_due = -1; err_due = -1; first_valid_due = -1; hs_cyc = -10;
        hs_idx = 0; blk_no = 0; req_cnt = 0; cap_we = 0; cap_addr = '0; cap_din = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_sd_rd_req"}, sd_rd_req, 0);
        check({tag, "_sram_we"}, sram_we, 0);
        check({tag, "_sram_addr"}, sram_addr, 0);
        check({tag, "_byte_valid"}, byte_valid, 0);
        check({tag, "_byte_last"}, byte_last, 0);
        check({tag, "_byte_data"}, byte_data, 0);
        check({tag, "_cur_blk"}, cur_blk, START_BLK);
    endtask

    // One clock cycle: update models, drive inputs after the edge, sample outputs 2 units after it.
    task automatic step(input bit do_start, input bit idle_stop, input bit do_reset);
        bit st;
        @(posedge clk);
        #1;
        cyc++;
        if (cap_we) mem[cap_addr] = cap_din;
        sram_dout = mem[cap_addr];

        reset = do_reset;
        start = do_start;
        stop  = idle_stop;
        st    = 0;
        if (sd_pend) begin
            sd_act = 1; sd_idx = 0; sd_pend = 0;
        end
        sd_valid = 0;
        sd_dout  = 8'($urandom);
        if (sd_act) begin
            if ($urandom_range(99) < 70) begin
                sd_valid = 1;
                sd_dout  = blk_byte(sd_addr, sd_idx);
            end
        end else if ($urandom_range(99) < 10) begin
            sd_valid = 1;
        end
        byte_ready = ($urandom_range(99) < ready_pct);
        if (!stop_sent) begin
            case (mode)
                M_FILL:  if (sd_act && req_cnt - 1 == stop_blk && sd_idx == 100) st = 1;
                M_DRAIN: if (draining && byte_valid && blk_no == stop_blk && hs_idx == 200) st = 1;
                M_LAST: if (draining && byte_valid && blk_no == stop_blk && hs_idx == 511) begin
                    st = 1;
                    byte_ready = 1;
                end
                default: ;
            endcase
        end
        if (st) begin
            stop = 1;
            stop_sent = 1;
            if (mode == M_FILL) fill_stop_pend = 1;
        end
        #1;

        if (do_reset) begin
            clear_model();
            return;
        end

        if (cyc == err_due) exp_err = 1;
        check("busy", busy, exp_busy);
        check("err", err, exp_err);
        check("done", done, cyc == done_due);
        if (done) done_cnt++;
        check("sd_rd_req", sd_rd_req, cyc == req_due);
        if (sd_rd_req) begin
            check("sd_blk_addr", sd_blk_addr, exp_addr);
            check("cur_blk_at_req", cur_blk, exp_addr);
            req_cnt++;
            sd_pend = 1;
            sd_addr = exp_addr;
        end

        if (sd_act && sd_valid) begin
            check("sram_we", sram_we, 1);
            check("sram_addr", sram_addr, sd_idx);
            check("sram_din", sram_din, blk_byte(sd_addr, sd_idx));
            sd_idx++;
            if (sd_idx == 512) begin
                sd_act = 0;
                if (fill_stop_pend) done_due = cyc + 2;
                else begin
                    first_valid_due = cyc + 4;
                    exp_drain_blk   = sd_addr;
                end
            end
        end else begin
            check("sram_we_off", sram_we, 0);
        end

        if (cyc == first_valid_due) begin
            draining = 1; hs_idx = 0; prev_hs = 0; prev_stall = 0; hs_cyc = -10;
            check("byte_valid_rise", byte_valid, 1);
            check("sram_block_content", mem_mismatches(exp_drain_blk), 0);
        end
        if (!draining) begin
            check("byte_valid_off", byte_valid, 0);
        end else begin
            if (prev_hs) check("handshake_gap", byte_valid, 0);
            if (cyc == hs_cyc + 2) check("next_byte_valid", byte_valid, 1);
            if (prev_stall) begin
                check("stall_valid", byte_valid, 1);
                check("stall_data", byte_data, prev_data);
                check("stall_last", byte_last, prev_last);
            end
            prev_hs    = byte_valid && byte_ready;
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
            prev_last  = byte_last;
            if (prev_hs) begin
                check("byte_data", byte_data, blk_byte(exp_drain_blk, hs_idx));
                check("byte_last", byte_last, hs_idx == 511);
                hs_idx++;
                hs_cyc = cyc;
            end
            if (stop) begin
                draining = 0;
                done_due = cyc + 1;
            end else if (prev_hs && hs_idx == 512) begin
                draining = 0;
                blk_no++;
                if (blk_no == MAX_BLKS) begin
                    done_due = cyc + 2;
                    err_due  = cyc + 2;
                end else begin
                    req_due  = cyc + 2;
                    exp_addr = exp_addr + 32'd1;
                end
            end
        end

        if (start && sd_init_finished && !exp_busy) begin
            exp_busy = 1; exp_err = 0; req_due = cyc + 1; exp_addr = START_BLK;
            blk_no = 0; req_cnt = 0; err_due = -1;
        end else if (cyc == done_due) begin
            exp_busy = 0;
        end
        cap_we   = sram_we;
        cap_addr = sram_addr;
        cap_din  = sram_din;
    endtask

    task automatic run_case(input run_t r);
        int budget;
        mode = r.mode; stop_blk = r.stop_blk; ready_pct = r.ready_pct;
        stop_sent = 0; fill_stop_pend = 0; done_cnt = 0;
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        budget = 0;
        while (exp_busy && budget < 20000) begin
            step($urandom_range(99) < 3, 0, 0);
            budget++;
        end
        check("run_finished", exp_busy, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("done_pulses", done_cnt, 1);
        check("blocks_read", req_cnt, r.exp_blocks);
        check("err_final", err, r.exp_err);
        check("cur_blk_final", cur_blk, r.exp_cur_blk);
        check("busy_final", busy, 0);
    endtask

    initial begin
        int budget;
        tbl[0] = '{M_NONE,  0, 100, 3, 1'b1, 32'h2002};
        tbl[1] = '{M_NONE,  0,  45, 3, 1'b1, 32'h2002};
        tbl[2] = '{M_FILL,  1,  70, 2, 1'b0, 32'h2001};
        tbl[3] = '{M_DRAIN, 0,  60, 1, 1'b0, 32'h2000};
        tbl[4] = '{M_LAST,  1,  50, 2, 1'b0, 32'h2001};
        tbl[5] = '{M_FILL,  0, 100, 1, 1'b0, 32'h2000};
        tbl[6] = '{M_LAST,  2,  80, 3, 1'b0, 32'h2002};

        n_checks = 0; n_pass = 0; cyc = 0;
        reset = 1; start = 0; stop = 0; sd_init_finished = 0;
        sd_valid = 0; sd_dout = '0; sram_dout = '0; byte_ready = 0;
        mode = M_NONE; ready_pct = 100; stop_sent = 0; fill_stop_pend = 0; done_cnt = 0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        clear_model();

        step(0, 0, 1);
        step(0, 0, 0);
        check_reset_vals("por");

        // start before sd_card initialisation must be ignored
        repeat (4) step(1, 0, 0);
        step(0, 1, 0);
        check("no_req_before_init", req_cnt, 0);
        sd_init_finished = 1;

        for (int k = 0; k < 7; k++) run_case(tbl[k]);

        // err is sticky after a limit run and cleared by reset
        run_case(tbl[0]);
        step(0, 0, 1);
        step(0, 0, 0);
        check_reset_vals("after_err");

        // reset in the middle of draining a sector
        mode = M_NONE; ready_pct = 100; stop_sent = 0; fill_stop_pend = 0;
        step(1, 0, 0);
        budget = 0;
        while (!(draining && hs_idx >= 20) && budget < 5000) begin
            step(0, 0, 0);
            budget++;
        end
        check("reached_drain", draining, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        check_reset_vals("mid_drain");

        // the sequencer must run normally again after the mid-run reset
        run_case(tbl[3]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
